// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
// master: producer+consumer side; slave: the arithmetic unit.
interface addsub_serial_if #(
  parameter int Width = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/addsub_serial.sv
// Serial add/sub, Chunk bits per clock, LSB slice first.
// Ports: clk, rst (sync, active-high), bus (addsub_serial_if.slave).
// Optional macro ADDSUB_SAT_EN clamps sum on signed overflow.
module addsub_serial #(
  parameter int Width = 10,
  parameter int Chunk = 2
) (
  input logic          clk,
  input logic          rst,
  addsub_serial_if.slave bus
);
  localparam int N  = Width / Chunk;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;
  logic [Width-1:0] acc;
  logic [Width-1:0] acc_n;
  logic             carry;
  logic [KW-1:0]    k;
  logic             a_msb;
  logic             bn_msb;
  logic [Width-1:0] sum_r;
  logic             c_out_r;
  logic             ovf_r;

  logic             accept;
  logic             last;
  logic             in_ready;
  logic [Chunk:0]   slice;
  logic [Width+Chunk-1:0] cat;
  logic             ovf_n;
  logic [Width-1:0] res;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
  assign bus.ovf       = ovf_r;

  assign accept = bus.in_valid & in_ready;
  assign last   = (k == KW'(N - 1));

  // One slice of the ripple; the new slice enters the
  // accumulator from the top so after N steps it is aligned.
  always_comb begin
    slice = {1'b0, op_a[Chunk-1:0]}
          + {1'b0, op_b[Chunk-1:0]}
          + {{Chunk{1'b0}}, carry};
    cat   = {slice[Chunk-1:0], acc};
    acc_n = cat[Width+Chunk-1:Chunk];
    // carry into MSB = a^b^s at the MSB position
    ovf_n = a_msb ^ bn_msb ^ acc_n[Width-1] ^ slice[Chunk];
    res   = acc_n;
`ifdef ADDSUB_SAT_EN
    if (ovf_n) begin
      res = a_msb ? {1'b1, {(Width-1){1'b0}}}
                  : {1'b0, {(Width-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) begin
          state_n = bus.in_valid ? RUN : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      k       <= '0;
      a_msb   <= 1'b0;
      bn_msb  <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_a   <= bus.a;
        op_b   <= bus.sub ? ~bus.b : bus.b;
        carry  <= bus.sub | bus.c_in;
        k      <= '0;
        a_msb  <= bus.a[Width-1];
        bn_msb <= bus.b[Width-1] ^ bus.sub;
      end else if (state == RUN) begin
        op_a  <= op_a >> Chunk;
        op_b  <= op_b >> Chunk;
        carry <= slice[Chunk];
        acc   <= acc_n;
        k     <= k + KW'(1);
        if (last) begin
          sum_r   <= res;
          c_out_r <= slice[Chunk];
          ovf_r   <= ovf_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (Width=10).
// Main checks on Chunk=2; reset/latency also on Chunk=1,10.
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  addsub_serial_if #(.Width(10)) i2 ();
  addsub_serial_if #(.Width(10)) i1 ();
  addsub_serial_if #(.Width(10)) i10 ();

  assign i1.in_valid   = i2.in_valid;
  assign i1.a          = i2.a;
  assign i1.b          = i2.b;
  assign i1.sub        = i2.sub;
  assign i1.c_in       = i2.c_in;
  assign i1.out_ready  = i2.out_ready;
  assign i10.in_valid  = i2.in_valid;
  assign i10.a         = i2.a;
  assign i10.b         = i2.b;
  assign i10.sub       = i2.sub;
  assign i10.c_in      = i2.c_in;
  assign i10.out_ready = i2.out_ready;

  addsub_serial #(.Width(10), .Chunk(2)) u2 (
    .clk(clk), .rst(rst), .bus(i2.slave));
  addsub_serial #(.Width(10), .Chunk(1)) u1 (
    .clk(clk), .rst(rst), .bus(i1.slave));
  addsub_serial #(.Width(10), .Chunk(10)) u10 (
    .clk(clk), .rst(rst), .bus(i10.slave));

  logic [2:0]  ov_all;
  logic [2:0]  ir_all;
  logic [29:0] sm_all;
  logic [5:0]  fl_all;
  assign ov_all = {i10.out_valid, i1.out_valid, i2.out_valid};
  assign ir_all = {i10.in_ready, i1.in_ready, i2.in_ready};
  assign sm_all = {i10.sum, i1.sum, i2.sum};
  assign fl_all = {i10.c_out, i10.ovf, i1.c_out, i1.ovf,
                   i2.c_out, i2.ovf};

  // Reference: signed/unsigned arithmetic on whole words.
  function automatic logic [11:0] model(
    input logic [9:0] ma, input logic [9:0] mb,
    input logic ms, input logic mc);
    int sa, sb, ex, tot;
    logic [9:0] s;
    logic co, ov;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      ex  = sa - sb;
      tot = int'(ma) + 1024 - int'(mb);
    end else begin
      ex  = sa + sb + int'(mc);
      tot = int'(ma) + int'(mb) + int'(mc);
    end
    s  = tot[9:0];
    co = tot[10];
    ov = (ex > 511) || (ex < -512);
`ifdef ADDSUB_SAT_EN
    if (ov) s = (sa >= 0) ? 10'h1FF : 10'h200;
`endif
    return {s, co, ov};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [9:0] ta,
    input logic [9:0] tb_, input logic ts, input logic tc);
    i2.a = ta; i2.b = tb_; i2.sub = ts; i2.c_in = tc;
    i2.in_valid = 1'b1;
    #1;
    checks++;
    if (i2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got=%b want=1", i2.in_ready);
    end
    tick;
    i2.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (i2.out_valid !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
  endtask

  task automatic finish_op;
    i2.out_ready = 1'b1;
    tick;
    i2.out_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic check_res(input string nm, input logic [11:0] exp);
    checks++;
    if ({i2.sum, i2.c_out, i2.ovf} !== exp) begin
      errors++;
      $display("FAIL %s got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
        nm, i2.sum, i2.c_out, i2.ovf, exp[11:2], exp[1], exp[0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++;
    if (ir_all !== 3'b000) begin
      errors++;
      $display("FAIL ready_in_rst got=%b want=000", ir_all);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ir_all !== 3'b111 || ov_all !== 3'b000 ||
        sm_all !== '0 || fl_all !== '0) begin
      errors++;
      $display("FAIL reset_state rdy=%b ov=%b sum=%h fl=%b",
        ir_all, ov_all, sm_all, fl_all);
    end
  endtask

  task automatic test_directed;
    logic [9:0] va [5] = '{300, 1023, 1023, 5, 10'h200};
    logic [9:0] vb [5] = '{300, 0, 1, 7, 1};
    logic       vs [5] = '{0, 0, 0, 1, 1};
    logic       vc [5] = '{0, 1, 0, 0, 0};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vs[i], vc[i]);
      wait_done(cyc);
      checks++;
      if (cyc != 5) begin
        errors++;
        $display("FAIL latency_%0d got=%0d want=5", i, cyc);
      end
      check_res($sformatf("directed_%0d", i),
        model(va[i], vb[i], vs[i], vc[i]));
      finish_op;
    end
  endtask

  task automatic test_random;
    logic [9:0] ra, rb;
    logic rs, rc;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      ra = 10'($urandom);
      rb = 10'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      start_op(ra, rb, rs, rc);
      // garbage and in_valid during RUN must be ignored
      i2.a = 10'($urandom);
      i2.b = 10'($urandom);
      i2.sub = 1'($urandom);
      i2.c_in = 1'($urandom);
      i2.in_valid = 1'b1;
      #1;
      checks++;
      if (i2.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL run_ready_%0d got=%b want=0", i, i2.in_ready);
      end
      wait_done(cyc);
      i2.in_valid = 1'b0;
      check_res($sformatf("random_%0d", i), model(ra, rb, rs, rc));
      repeat ($urandom_range(0, 2)) tick;
      finish_op;
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] e1;
    int cyc;
    e1 = model(10'd1, 10'd1, 1'b0, 1'b0);
    start_op(10'd1, 10'd1, 1'b0, 1'b0);
    wait_done(cyc);
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (i2.out_valid !== 1'b1 || i2.in_ready !== 1'b0 ||
          {i2.sum, i2.c_out, i2.ovf} !== e1) begin
        errors++;
        $display("FAIL hold_%0d ov=%b rdy=%b sum=%h want ov=1 rdy=0 sum=%h",
          i, i2.out_valid, i2.in_ready, i2.sum, e1[11:2]);
      end
    end
    i2.a = 10'd2; i2.b = 10'd3; i2.sub = 1'b0; i2.c_in = 1'b0;
    i2.in_valid = 1'b1;
    i2.out_ready = 1'b1;
    #1;
    checks++;
    if (i2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got=%b want=1", i2.in_ready);
    end
    tick;
    i2.in_valid = 1'b0;
    i2.out_ready = 1'b0;
    checks++;
    if (i2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_run got ov=%b want 0", i2.out_valid);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL b2b_latency got=%0d want=5", cyc);
    end
    check_res("b2b_sum", model(10'd2, 10'd3, 1'b0, 1'b0));
    finish_op;
  endtask

  task automatic test_reset_midrun;
    int lat [3];
    int want [3] = '{5, 10, 1};
    logic [9:0] s8;
    do_reset;
    start_op(10'd100, 10'd100, 1'b0, 1'b0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    checks++;
    if (ov_all !== 3'b000 || sm_all !== '0 || fl_all !== '0) begin
      errors++;
      $display("FAIL midrun_rst ov=%b sum=%h fl=%b want zeros",
        ov_all, sm_all, fl_all);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ir_all !== 3'b111) begin
      errors++;
      $display("FAIL midrun_idle rdy=%b want=111", ir_all);
    end
    tick;
    checks++;
    if (ov_all !== 3'b000) begin
      errors++;
      $display("FAIL partial_shown ov=%b want=000", ov_all);
    end
    start_op(10'd4, 10'd4, 1'b0, 1'b0);
    lat = '{-1, -1, -1};
    for (int c = 0; c < 15; c++) begin
      for (int j = 0; j < 3; j++) begin
        if (ov_all[j] === 1'b1 && lat[j] < 0) lat[j] = c;
      end
      tick;
    end
    s8 = model(10'd4, 10'd4, 1'b0, 1'b0) >> 2;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (lat[j] != want[j] || sm_all[j*10 +: 10] !== s8) begin
        errors++;
        $display("FAIL n%0d_latency lat=%0d sum=%h want lat=%0d sum=%h",
          want[j], lat[j], sm_all[j*10 +: 10], want[j], s8);
      end
    end
    finish_op;
  endtask

  initial begin
    i2.in_valid = 1'b0;
    i2.out_ready = 1'b0;
    i2.a = '0;
    i2.b = '0;
    i2.sub = 1'b0;
    i2.c_in = 1'b0;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_midrun;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
